// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter.
//   - state_t : arbiter FSM encoding (also visible on the debug state port)
//   - grant_t : which requester received the most recent grant
//   - AW_DEFAULT / DW_DEFAULT : default address and data widths
package mem_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_C = 2'd1,
        BUSY_L = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_CORE = 1'b0,
        GRANT_LDR  = 1'b1
    } grant_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a last-grant register.
//   clk, rst   : clock, asynchronous active-low reset
//   req_c      : core request
//   req_l      : loader request
//   take       : the owner accepts the current grant (updates last_grant)
//   gnt_c      : core wins this cycle (combinational)
//   gnt_l      : loader wins this cycle (combinational)
module rr_arb2
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_c,
    input  logic req_l,
    input  logic take,
    output logic gnt_c,
    output logic gnt_l
);

    grant_t last_grant;

    // A lone requester always wins; on a tie the side that did not win
    // last time gets the grant, so neither side can be starved.
    always_comb begin
        gnt_c = 1'b0;
        gnt_l = 1'b0;
        if (req_c && req_l) begin
            if (last_grant == GRANT_LDR) gnt_c = 1'b1;
            else                         gnt_l = 1'b1;
        end else begin
            gnt_c = req_c;
            gnt_l = req_l;
        end
    end

    // Reset leaves the loader as last winner, so the core wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= GRANT_LDR;
        end else if (take && (gnt_c || gnt_l)) begin
            last_grant <= gnt_c ? GRANT_CORE : GRANT_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified instruction/data memory between the multi-cycle core
// and a program-loader/debug port.
//   clk, rst                : clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata : core request side (inputs)
//   c_rdata, c_ack          : core read data and 1-cycle completion pulse
//   l_*                     : loader side, identical to the core side
//   mem_en/mem_we/mem_addr/mem_wdata : registered memory command
//   mem_rdata, mem_ready    : memory response (rdata valid with ready)
//   core_stall              : c_req & ~c_ack, holds the core control FSM
//   timeout_err             : sticky, set when an access is aborted
//   dbg_state               : current FSM state
//
// Handshake: a requester raises x_req with stable x_we/x_addr/x_wdata and
// keeps it high until x_ack. x_ack is a single-cycle pulse; x_rdata is valid
// in that cycle. Once granted, an access always completes and acks even if
// the request is dropped. A request still high during its ack cycle is only
// considered again from IDLE. On the memory side mem_en stays high until
// mem_ready, or until the wait budget runs out and the access is aborted.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int AW       = AW_DEFAULT,
    parameter int DW       = DW_DEFAULT,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_ack,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic [DW-1:0] l_rdata,
    output logic          l_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          core_stall,
    output logic          timeout_err,
    output logic [1:0]    dbg_state
);

    localparam logic [7:0] MAX_WAIT_U = 8'(MAX_WAIT);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_inc;
    logic       gnt_c;
    logic       gnt_l;
    logic       in_idle;
    logic       timed_out;
    logic       finish;

    assign in_idle = (state == IDLE);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_c (c_req),
        .req_l (l_req),
        .take  (in_idle),
        .gnt_c (gnt_c),
        .gnt_l (gnt_l)
    );

    // Saturating count of BUSY cycles including the current one, so the
    // abort fires at the end of BUSY cycle number MAX_WAIT.
    assign wait_cnt_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    assign timed_out    = !mem_ready && (wait_cnt_inc == MAX_WAIT_U);
    assign finish       = mem_ready || timed_out;

    assign core_stall = c_req & ~c_ack;
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            c_rdata     <= '0;
            l_rdata     <= '0;
            c_ack       <= 1'b0;
            l_ack       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            c_ack <= 1'b0;
            l_ack <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= 8'd0;
                    if (gnt_c) begin
                        state     <= BUSY_C;
                        mem_en    <= 1'b1;
                        mem_we    <= c_we;
                        mem_addr  <= c_addr;
                        mem_wdata <= c_wdata;
                    end else if (gnt_l) begin
                        state     <= BUSY_L;
                        mem_en    <= 1'b1;
                        mem_we    <= l_we;
                        mem_addr  <= l_addr;
                        mem_wdata <= l_wdata;
                    end
                end
                BUSY_C, BUSY_L: begin
                    wait_cnt <= wait_cnt_inc;
                    if (finish) begin
                        state  <= DONE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (timed_out) timeout_err <= 1'b1;
                        // Aborted accesses return zero; completed writes
                        // leave the requester's read data untouched.
                        if (state == BUSY_C) begin
                            c_ack <= 1'b1;
                            if (timed_out)    c_rdata <= '0;
                            else if (!mem_we) c_rdata <= mem_rdata;
                        end else begin
                            l_ack <= 1'b1;
                            if (timed_out)    l_rdata <= '0;
                            else if (!mem_we) l_rdata <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    wait_cnt <= 8'd0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_WAIT = 15;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  logic          clk;
  logic          rst;
  logic          c_req, c_we, l_req, l_we;
  logic [AW-1:0] c_addr, l_addr;
  logic [DW-1:0] c_wdata, l_wdata;
  logic [DW-1:0] c_rdata, l_rdata;
  logic          c_ack, l_ack;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;
  logic          core_stall, timeout_err;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  // memory responder controls (0 = random latency 1..4)
  int            resp_delay = 1;
  bit            resp_fixed = 0;
  logic [DW-1:0] resp_data  = '0;
  bit            noise_en   = 0;

  // scoreboard: data the memory delivered and the command it saw
  logic [DW-1:0] exp_q[$];
  acc_t          acc_q[$];

  // reference model of requester-visible state
  logic [DW-1:0] model_c_rdata, model_l_rdata;
  bit            model_err;
  bit            model_last; // 1 = loader won the last grant

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rdata(l_rdata), .l_ack(l_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .core_stall(core_stall), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- memory responder ----------------
  initial begin : responder
    int   busy_cyc;
    int   target;
    acc_t snap;
    busy_cyc = 0;
    target = 0;
    snap = '0;
    mem_ready = 0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 0;
      mem_rdata = $urandom();
      if (!rst) begin
        busy_cyc = 0;
      end else if (mem_en) begin
        busy_cyc++;
        if (busy_cyc == 1) begin
          snap.we = mem_we; snap.addr = mem_addr; snap.wdata = mem_wdata;
          target = (resp_delay > 0) ? resp_delay : int'($urandom_range(1, 4));
        end else begin
          checks++;
          if ({mem_we, mem_addr, mem_wdata} !== snap) begin
            errors++;
            $display("FAIL mem_hold: got we=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h",
                     mem_we, mem_addr, mem_wdata, snap.we, snap.addr, snap.wdata);
          end
        end
        if (busy_cyc == target) begin
          mem_ready = 1;
          if (resp_fixed) mem_rdata = resp_data;
          exp_q.push_back(mem_rdata);
          acc_q.push_back(snap);
        end
      end else begin
        busy_cyc = 0;
        if (noise_en) mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 0;
    c_req = 0; l_req = 0; c_we = 0; l_we = 0;
    c_addr = '0; l_addr = '0; c_wdata = '0; l_wdata = '0;
    noise_en = 0; resp_fixed = 0; resp_delay = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    model_c_rdata = '0; model_l_rdata = '0; model_err = 0; model_last = 1;
  endtask

  // One isolated access by one requester; delay = BUSY cycle carrying
  // mem_ready, values above MAX_WAIT mean the memory never answers.
  task automatic do_access(input bit who, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int delay, input string name);
    int k, en_cnt, exp_lat, exp_en;
    bit seen, other_seen, exp_to;
    logic [DW-1:0] d, exp_rd, got_rd;
    acc_t exp_acc, got_acc;
    exp_q.delete(); acc_q.delete();
    resp_delay = delay;
    exp_to  = (delay > MAX_WAIT);
    exp_lat = exp_to ? MAX_WAIT + 1 : delay + 1;
    exp_en  = exp_to ? MAX_WAIT : delay;
    @(posedge clk); #1;
    if (!who) begin c_we = we; c_addr = addr; c_wdata = wdata; c_req = 1; end
    else      begin l_we = we; l_addr = addr; l_wdata = wdata; l_req = 1; end
    k = 0; en_cnt = 0; seen = 0; other_seen = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      if (!who && k == 0) begin
        checks++;
        if (core_stall !== 1'b1) begin
          errors++; $display("FAIL %s_stall_req: got %b exp 1", name, core_stall);
        end
      end
      if (who ? c_ack : l_ack) other_seen = 1;
      if (who ? l_ack : c_ack) seen = 1;
      else begin
        k++;
        if (mem_en) en_cnt++;
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_ack: no ack within 40 cycles", name); end
    checks++;
    if (k != exp_lat) begin errors++; $display("FAIL %s_latency: got %0d exp %0d", name, k, exp_lat); end
    checks++;
    if (en_cnt != exp_en) begin errors++; $display("FAIL %s_mem_en_cycles: got %0d exp %0d", name, en_cnt, exp_en); end
    checks++;
    if (other_seen) begin errors++; $display("FAIL %s_other_ack: got 1 exp 0", name); end
    checks++;
    if (mem_en !== 1'b0) begin errors++; $display("FAIL %s_bubble_mem_en: got %b exp 0", name, mem_en); end
    if (!who) begin
      checks++;
      if (core_stall !== 1'b0) begin errors++; $display("FAIL %s_stall_ack: got %b exp 0", name, core_stall); end
    end
    exp_rd = who ? model_l_rdata : model_c_rdata;
    if (exp_to) begin
      exp_rd = '0;
    end else begin
      d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      if (!we) exp_rd = d;
      exp_acc.we = we; exp_acc.addr = addr; exp_acc.wdata = wdata;
      got_acc = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
      checks++;
      if (got_acc !== exp_acc) begin
        errors++;
        $display("FAIL %s_mem_cmd: got we=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h",
                 name, got_acc.we, got_acc.addr, got_acc.wdata, we, addr, wdata);
      end
    end
    got_rd = who ? l_rdata : c_rdata;
    checks++;
    if (got_rd !== exp_rd) begin errors++; $display("FAIL %s_rdata: got %h exp %h", name, got_rd, exp_rd); end
    if (who) model_l_rdata = exp_rd; else model_c_rdata = exp_rd;
    model_err  = model_err | exp_to;
    model_last = who;
    checks++;
    if (timeout_err !== model_err) begin errors++; $display("FAIL %s_timeout_err: got %b exp %b", name, timeout_err, model_err); end
    @(posedge clk); #1;
    c_req = 0; l_req = 0;
    @(negedge clk);
    checks++;
    if ({c_ack, l_ack} !== 2'b00) begin errors++; $display("FAIL %s_single_ack: got %b exp 00", name, {c_ack, l_ack}); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({c_ack, l_ack, mem_en, mem_we, core_stall, timeout_err} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b exp 000000", {c_ack, l_ack, mem_en, mem_we, core_stall, timeout_err});
    end
    checks++;
    if ({c_rdata, l_rdata} !== '0) begin errors++; $display("FAIL reset_rdata: got %h %h exp 0 0", c_rdata, l_rdata); end
    checks++;
    if ({mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL reset_mem_regs: got %h %h exp 0 0", mem_addr, mem_wdata); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
  endtask

  task automatic test_round_robin();
    int n, cyc, quiet;
    bit exp_ldr;
    logic [DW-1:0] d, got;
    apply_reset();
    exp_q.delete(); acc_q.delete();
    resp_delay = 0;
    @(posedge clk); #1;
    c_we = 0; l_we = 0; c_addr = 32'h100; l_addr = 32'h200; c_req = 1; l_req = 1;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (c_ack || l_ack) begin
        exp_ldr = ~model_last;
        checks++;
        if ({c_ack, l_ack} !== (exp_ldr ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL rr_order_%0d: got c_ack,l_ack=%b exp %b", n, {c_ack, l_ack}, exp_ldr ? 2'b01 : 2'b10);
        end
        d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        got = exp_ldr ? l_rdata : c_rdata;
        checks++;
        if (got !== d) begin errors++; $display("FAIL rr_rdata_%0d: got %h exp %h", n, got, d); end
        if (exp_ldr) model_l_rdata = d; else model_c_rdata = d;
        model_last = exp_ldr;
        n++;
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL rr_count: got %0d acks exp 4", n); end
    @(posedge clk); #1;
    c_req = 0; l_req = 0;
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      if (c_ack || l_ack || mem_en) quiet++;
    end
    checks++;
    if (quiet != 0) begin errors++; $display("FAIL rr_idle_after_drop: got %0d busy cycles exp 0", quiet); end
  endtask

  task automatic test_core_read();
    resp_fixed = 1;
    resp_data  = 32'hDEADBEEF;
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 2, "core_read");
    resp_fixed = 0;
  endtask

  task automatic test_loader_write();
    do_access(1'b1, 1'b1, 32'h40, 32'h0000_0013, 3, "ldr_write");
  endtask

  task automatic test_timeout();
    do_access(1'b0, 1'b0, 32'h24, 32'h0, 999, "timeout");
    do_access(1'b0, 1'b0, 32'h28, 32'h0, 2, "after_timeout");
  endtask

  task automatic test_stall_drop();
    int k, n;
    logic [DW-1:0] d;
    exp_q.delete(); acc_q.delete();
    resp_delay = 5;
    @(posedge clk); #1;
    c_we = 0; c_addr = 32'h300; c_req = 1;
    @(negedge clk);
    checks++;
    if (core_stall !== 1'b1) begin errors++; $display("FAIL stall_high: got %b exp 1", core_stall); end
    k = 0;
    while (!mem_en && k < 10) begin @(negedge clk); k++; end
    checks++;
    if (mem_en !== 1'b1) begin errors++; $display("FAIL stall_grant: got mem_en=%b exp 1", mem_en); end
    @(posedge clk); #1;
    c_req = 0;
    @(negedge clk);
    checks++;
    if (core_stall !== 1'b0) begin errors++; $display("FAIL stall_drop: got %b exp 0", core_stall); end
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (c_ack) n++;
    end
    checks++;
    if (n != 1) begin errors++; $display("FAIL stall_ack_count: got %0d exp 1", n); end
    d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (c_rdata !== d) begin errors++; $display("FAIL stall_rdata: got %h exp %h", c_rdata, d); end
    model_c_rdata = d;
    model_last = 0;
  endtask

  task automatic test_reset_mid();
    int k;
    logic [DW-1:0] d;
    exp_q.delete(); acc_q.delete();
    resp_delay = 999;
    @(posedge clk); #1;
    l_we = 1; l_addr = 32'h80; l_wdata = $urandom(); l_req = 1;
    k = 0;
    while (!mem_en && k < 10) begin @(negedge clk); k++; end
    checks++;
    if (dbg_state !== 2'd2) begin errors++; $display("FAIL rstmid_busy_l: got state %0d exp 2", dbg_state); end
    @(posedge clk); #1;
    rst = 0;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      checks++;
      if ({c_ack, l_ack, mem_en, mem_we, core_stall, timeout_err, dbg_state} !== 8'b0) begin
        errors++; $display("FAIL rstmid_flags_%0d: got %b exp 00000000", r,
                           {c_ack, l_ack, mem_en, mem_we, core_stall, timeout_err, dbg_state});
      end
      checks++;
      if ({mem_addr, mem_wdata, c_rdata, l_rdata} !== '0) begin
        errors++; $display("FAIL rstmid_regs_%0d: got %h %h %h %h exp 0", r, mem_addr, mem_wdata, c_rdata, l_rdata);
      end
    end
    l_req = 0; l_we = 0;
    rst = 1;
    model_c_rdata = '0; model_l_rdata = '0; model_err = 0; model_last = 1;
    exp_q.delete(); acc_q.delete();
    resp_delay = 2;
    @(posedge clk); #1;
    c_we = 0; l_we = 0; c_addr = 32'h500; l_addr = 32'h600; c_req = 1; l_req = 1;
    k = 0;
    while (!(c_ack || l_ack) && k < 20) begin @(negedge clk); k++; end
    checks++;
    if ({c_ack, l_ack} !== 2'b10) begin errors++; $display("FAIL rstmid_core_first: got %b exp 10", {c_ack, l_ack}); end
    d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (c_rdata !== d) begin errors++; $display("FAIL rstmid_rdata: got %h exp %h", c_rdata, d); end
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL rstmid_err_cleared: got %b exp 0", timeout_err); end
    model_c_rdata = d;
    model_last = 0;
    @(posedge clk); #1;
    c_req = 0; l_req = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    apply_reset();
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL rand_err_cleared: got %b exp 0", timeout_err); end
    noise_en = 1;
    for (int i = 0; i < 30; i++) begin
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom() & 32'hFFFF_FFFC, $urandom(),
                int'($urandom_range(1, MAX_WAIT + 3)), $sformatf("rand%0d", i));
    end
    noise_en = 0;
  endtask

  // ---------------- main ----------------
  initial begin
    rst = 1;
    c_req = 0; l_req = 0; c_we = 0; l_we = 0;
    c_addr = '0; l_addr = '0; c_wdata = '0; l_wdata = '0;
    model_c_rdata = '0; model_l_rdata = '0; model_err = 0; model_last = 1;
    test_reset();
    test_round_robin();
    test_core_read();
    test_loader_write();
    test_timeout();
    test_stall_drop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
